score_hex_display: RTL and testbench

Downstream consumer of the game core's 16-bit `score` output. It converts the score to five BCD digits with a sequential double-dabble engine, one bit per cycle. It drives five active-low seven-segment displays (HEX4..HEX0) with optional leading-zero blanking. It also exposes the BCD value for other consumers and can blink the display while `game_over` is asserted.

---
 rtl/score_hex_display.sv | 157 +++++++++++++++
 tb/tb_score_hex_display.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/score_hex_display.sv
// score_hex_display: converts the game score to five BCD digits with a
// sequential double-dabble engine (one bit per cycle) and drives five
// active-low seven-segment displays, with optional leading-zero blanking.
// Optional feature macro: SCORE_BLINK_EN (blink the display during game_over).
module score_hex_display #(
   parameter int unsigned BLINK_DIV = 25_000_000,
   parameter int unsigned LZ_BLANK  = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] score,
   input  logic        game_over,
   output logic [19:0] bcd,
   output logic        busy,
   output logic [6:0]  HEX0,
   output logic [6:0]  HEX1,
   output logic [6:0]  HEX2,
   output logic [6:0]  HEX3,
   output logic [6:0]  HEX4
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CONV = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [6:0] SEG_BLANK  = 7'b1111111;
   localparam logic [6:0] SEG_ZERO   = 7'b1000000;
   localparam logic [6:0] SEG_RST_HI = (LZ_BLANK != 0) ? SEG_BLANK : SEG_ZERO;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b1000000;
         4'd1:    seg7 = 7'b1111001;
         4'd2:    seg7 = 7'b0100100;
         4'd3:    seg7 = 7'b0110000;
         4'd4:    seg7 = 7'b0011001;
         4'd5:    seg7 = 7'b0010010;
         4'd6:    seg7 = 7'b0000010;
         4'd7:    seg7 = 7'b1111000;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0010000;
         default: seg7 = SEG_BLANK;
      endcase
   endfunction

   logic [1:0]       state_q;
   logic [15:0]      last_score_q;
   logic [15:0]      sh_q;
   logic [19:0]      acc_q;
   logic [3:0]       cnt_q;
   logic [19:0]      bcd_q;
   logic [4:0][6:0]  hex_q;

   logic [19:0]      adj;
   logic [35:0]      shifted;
   logic [4:0]       lz;
   logic [4:0][6:0]  seg_d;
   logic             blank_all;

   // One double-dabble step: correct digits >= 5, then shift {acc,sh} left.
   always_comb begin
      adj = acc_q;
      for (int i = 0; i < 5; i++) begin
         if (acc_q[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
         end
      end
      shifted = {adj, sh_q} << 1;
   end

   // Segment patterns for the finished accumulator, with leading-zero blanking.
   always_comb begin
      lz    = '0;
      lz[4] = (LZ_BLANK != 0) && (acc_q[19:16] == 4'd0);
      for (int k = 3; k >= 1; k--) begin
         lz[k] = lz[k+1] && (acc_q[4*k +: 4] == 4'd0);
      end
      for (int k = 0; k < 5; k++) begin
         seg_d[k] = lz[k] ? SEG_BLANK : seg7(acc_q[4*k +: 4]);
      end
   end

   // Conversion FSM and output registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         last_score_q <= '0;
         sh_q         <= '0;
         acc_q        <= '0;
         cnt_q        <= '0;
         bcd_q        <= '0;
         hex_q        <= {SEG_RST_HI, SEG_RST_HI, SEG_RST_HI, SEG_RST_HI, SEG_ZERO};
      end else begin
         case (state_q)
            IDLE: begin
               // last_score holds the value in flight, so later changes are re-detected here.
               if (score != last_score_q) begin
                  sh_q         <= score;
                  last_score_q <= score;
                  acc_q        <= '0;
                  cnt_q        <= '0;
                  state_q      <= CONV;
               end
            end
            CONV: begin
               acc_q <= shifted[35:16];
               sh_q  <= shifted[15:0];
               cnt_q <= cnt_q + 4'd1;
               if (cnt_q == 4'd15) begin
                  state_q <= DONE;
               end
            end
            DONE: begin
               bcd_q   <= acc_q;
               hex_q   <= seg_d;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef SCORE_BLINK_EN
   localparam int unsigned BW = $clog2(BLINK_DIV);

   logic [BW-1:0] blink_cnt_q;
   logic          phase_q;

   // Blink timer: toggles phase every BLINK_DIV cycles while game_over is high.
   always_ff @(posedge clk) begin
      if (!rst || !game_over) begin
         blink_cnt_q <= '0;
         phase_q     <= 1'b0;
      end else if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
         blink_cnt_q <= '0;
         phase_q     <= ~phase_q;
      end else begin
         blink_cnt_q <= blink_cnt_q + 1'b1;
      end
   end

   assign blank_all = phase_q;
`else
   logic unused_cfg;
   assign unused_cfg = ^{game_over, BLINK_DIV[0]};
   assign blank_all  = 1'b0;
`endif

   assign bcd  = bcd_q;
   assign busy = (state_q != IDLE);
   assign HEX0 = blank_all ? SEG_BLANK : hex_q[0];
   assign HEX1 = blank_all ? SEG_BLANK : hex_q[1];
   assign HEX2 = blank_all ? SEG_BLANK : hex_q[2];
   assign HEX3 = blank_all ? SEG_BLANK : hex_q[3];
   assign HEX4 = blank_all ? SEG_BLANK : hex_q[4];

endmodule

// File: tb/tb_score_hex_display.sv
// Directed bench for score_hex_display: one DUT with leading-zero blanking,
// one without, sharing the same stimulus.
module tb_score_hex_display;

   localparam logic [6:0] S0 = 7'b1000000;
   localparam logic [6:0] S1 = 7'b1111001;
   localparam logic [6:0] S2 = 7'b0100100;
   localparam logic [6:0] S3 = 7'b0110000;
   localparam logic [6:0] S5 = 7'b0010010;
   localparam logic [6:0] S6 = 7'b0000010;
   localparam logic [6:0] S7 = 7'b1111000;
   localparam logic [6:0] S9 = 7'b0010000;
   localparam logic [6:0] SB = 7'b1111111;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] score;
   logic        game_over;

   logic [19:0] bcd, bcd0;
   logic        busy, busy0;
   logic [6:0]  hex0, hex1, hex2, hex3, hex4;
   logic [6:0]  z0, z1, z2, z3, z4;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   score_hex_display #(.BLINK_DIV(4), .LZ_BLANK(1)) dut (
      .clk(clk), .rst(rst), .score(score), .game_over(game_over),
      .bcd(bcd), .busy(busy),
      .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .HEX3(hex3), .HEX4(hex4)
   );

   score_hex_display #(.BLINK_DIV(4), .LZ_BLANK(0)) dut0 (
      .clk(clk), .rst(rst), .score(score), .game_over(game_over),
      .bcd(bcd0), .busy(busy0),
      .HEX0(z0), .HEX1(z1), .HEX2(z2), .HEX3(z3), .HEX4(z4)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst       = 1'b0;
      score     = 16'd0;
      game_over = 1'b0;
      repeat (3) tick();
      check("rst_bcd", bcd, 20'h0);
      check("rst_busy", {19'd0, busy}, 20'h0);
      check("rst_hex0", {13'd0, hex0}, {13'd0, S0});
      check("rst_hex1", {13'd0, hex1}, {13'd0, SB});
      check("rst_hex4", {13'd0, hex4}, {13'd0, SB});
      check("rst_nolz_hex1", {13'd0, z1}, {13'd0, S0});
      check("rst_nolz_hex4", {13'd0, z4}, {13'd0, S0});

      rst = 1'b1;
      tick();
      check("idle_same_score", {19'd0, busy}, 20'h0);

      // 0 -> 123: edge k starts, k+1..k+16 convert, k+17 completes.
      score = 16'd123;
      tick();
      check("busy_start", {19'd0, busy}, 20'h1);
      for (int i = 0; i < 16; i++) begin
         tick();
         check("busy_conv", {19'd0, busy}, 20'h1);
      end
      check("bcd_before_done", bcd, 20'h0);
      tick();
      check("busy_fall", {19'd0, busy}, 20'h0);
      check("bcd_123", bcd, 20'h00123);
      check("h123_hex0", {13'd0, hex0}, {13'd0, S3});
      check("h123_hex1", {13'd0, hex1}, {13'd0, S2});
      check("h123_hex2", {13'd0, hex2}, {13'd0, S1});
      check("h123_hex3", {13'd0, hex3}, {13'd0, SB});
      check("h123_hex4", {13'd0, hex4}, {13'd0, SB});

      score = 16'd65535;
      repeat (18) tick();
      check("bcd_max", bcd, 20'h65535);
      check("max_hex4", {13'd0, hex4}, {13'd0, S6});
      check("max_hex3", {13'd0, hex3}, {13'd0, S5});
      check("max_hex0", {13'd0, hex0}, {13'd0, S5});

      score = 16'd7;
      repeat (18) tick();
      check("nolz7_bcd", bcd0, 20'h00007);
      check("nolz7_hex0", {13'd0, z0}, {13'd0, S7});
      check("nolz7_hex1", {13'd0, z1}, {13'd0, S0});
      check("nolz7_hex2", {13'd0, z2}, {13'd0, S0});
      check("nolz7_hex3", {13'd0, z3}, {13'd0, S0});
      check("nolz7_hex4", {13'd0, z4}, {13'd0, S0});
      check("lz7_hex1", {13'd0, hex1}, {13'd0, SB});

      // Score changes during CONV: first result is the latched value.
      score = 16'd10;
      tick();
      repeat (5) tick();
      score = 16'd42;
      repeat (12) tick();
      check("midchg_first", bcd, 20'h00010);
      repeat (17) tick();
      check("midchg_hold", bcd, 20'h00010);
      repeat (2) tick();
      check("midchg_second", bcd, 20'h00042);
      check("midchg_idle", {19'd0, busy}, 20'h0);

      // Reset during CONV discards the partial conversion.
      score = 16'd999;
      tick();
      repeat (7) tick();
      check("pre_rst_busy", {19'd0, busy}, 20'h1);
      rst = 1'b0;
      tick();
      check("midrst_busy", {19'd0, busy}, 20'h0);
      check("midrst_bcd", bcd, 20'h0);
      check("midrst_hex0", {13'd0, hex0}, {13'd0, S0});
      rst = 1'b1;
      repeat (18) tick();
      check("after_rst_bcd", bcd, 20'h00999);
      check("after_rst_hex2", {13'd0, hex2}, {13'd0, S9});
      check("after_rst_hex3", {13'd0, hex3}, {13'd0, SB});

`ifdef SCORE_BLINK_EN
      score = 16'd5;
      repeat (18) tick();
      check("blink_bcd", bcd, 20'h00005);
      game_over = 1'b1;
      repeat (3) tick();
      check("blink_ph0", {13'd0, hex0}, {13'd0, S5});
      tick();
      check("blink_ph1", {13'd0, hex0}, {13'd0, SB});
      repeat (3) tick();
      check("blink_ph1_hold", {13'd0, hex0}, {13'd0, SB});
      tick();
      check("blink_ph0_again", {13'd0, hex0}, {13'd0, S5});
      repeat (4) tick();
      check("blink_ph1_again", {13'd0, hex0}, {13'd0, SB});
      game_over = 1'b0;
      tick();
      check("blink_restore", {13'd0, hex0}, {13'd0, S5});
      check("blink_bcd_kept", bcd, 20'h00005);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
